// File: rtl/uart_cmd_controller_if.sv
// Bundles the receive, sensor and transmit handshakes of the command controller.
// The master modport is the controller side and the slave modport is the surrounding system.
interface uart_cmd_controller_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_endofpacket;
  logic       sensor_start;
  logic [4:0] sensor_sel;
  logic [7:0] sensor_code;
  logic       sensor_done;
  logic       sensor_error;
  logic [7:0] sensor_value;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;
  logic       dropped;

  modport master (
    input  rx_ready, rx_data, rx_endofpacket,
    input  sensor_done, sensor_error, sensor_value,
    input  tx_busy,
    output sensor_start, sensor_sel, sensor_code,
    output tx_start, tx_data,
    output busy, dropped
  );

  modport slave (
    output rx_ready, rx_data, rx_endofpacket,
    output sensor_done, sensor_error, sensor_value,
    output tx_busy,
    input  sensor_start, sensor_sel, sensor_code,
    input  tx_start, tx_data,
    input  busy, dropped
  );
endinterface

// File: rtl/uart_cmd_controller.sv
// Command sequencer: collects a 2-byte frame (code, sensor address) from the UART
// receiver, validates it, runs one sensor read with a timeout and returns a
// 2-byte response through the UART transmitter.
module uart_cmd_controller #(
  parameter int unsigned ClkFrequency  = 50000000,
  parameter int unsigned TimeoutCycles = ClkFrequency,
  parameter int unsigned NumSensors    = 32
) (
  input logic                   clk,
  input logic                   reset,
  uart_cmd_controller_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WAIT_ADDR, CHECK, REQ, WAIT_SENSOR, SEND0, WAIT_TX0, SEND1, WAIT_TX1
  } state_t;

  state_t      state, state_next;
  logic [7:0]  code_q, code_next;
  logic [7:0]  addr_q, addr_next;
  logic [7:0]  resp0_q, resp0_next;
  logic [7:0]  resp1_q, resp1_next;
  logic [31:0] cnt_q, cnt_next;
  logic        sensor_start;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        dropped_q;

  assign busy = !(state inside {IDLE, WAIT_ADDR});

  // State and frame/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      code_q  <= '0;
      addr_q  <= '0;
      resp0_q <= '0;
      resp1_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_next;
      code_q  <= code_next;
      addr_q  <= addr_next;
      resp0_q <= resp0_next;
      resp1_q <= resp1_next;
      cnt_q   <= cnt_next;
    end
  end

  // Sticky flag for bytes that arrive while a frame is being processed.
  always_ff @(posedge clk) begin
    if (reset)
      dropped_q <= 1'b0;
    else if (bus.rx_ready && busy)
      dropped_q <= 1'b1;
  end

  // Next-state, register updates and strobe outputs.
  always_comb begin
    state_next   = state;
    code_next    = code_q;
    addr_next    = addr_q;
    resp0_next   = resp0_q;
    resp1_next   = resp1_q;
    cnt_next     = cnt_q;
    sensor_start = 1'b0;
    tx_start     = 1'b0;
    tx_data      = '0;
    case (state)
      IDLE: begin
        if (bus.rx_ready) begin
          code_next  = bus.rx_data;
          state_next = WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        if (bus.rx_ready) begin
          addr_next  = bus.rx_data;
          state_next = CHECK;
        end else if (bus.rx_endofpacket) begin
          code_next  = '0;
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (code_q > 8'h02) begin
          resp0_next = 8'h0E;
          resp1_next = code_q;
          state_next = SEND0;
        end else if ({24'h0, addr_q} >= NumSensors) begin
          resp0_next = 8'h0F;
          resp1_next = addr_q;
          state_next = SEND0;
        end else begin
          state_next = REQ;
        end
      end
      REQ: begin
        sensor_start = 1'b1;
        cnt_next     = '0;
        state_next   = WAIT_SENSOR;
      end
      WAIT_SENSOR: begin
        // A result on the timeout cycle is tested first so it takes precedence.
        if (bus.sensor_done) begin
          state_next = SEND0;
          resp1_next = 8'h00;
          if (bus.sensor_error) begin
            resp0_next = 8'h1F;
          end else begin
            case (code_q)
              8'h00:   resp0_next = 8'h07;
              8'h01: begin
                resp0_next = 8'h09;
                resp1_next = bus.sensor_value;
              end
              default: begin
                resp0_next = 8'h08;
                resp1_next = bus.sensor_value;
              end
            endcase
          end
        end else if (cnt_q == TimeoutCycles - 32'd1) begin
          resp0_next = 8'h1E;
          resp1_next = 8'h00;
          state_next = SEND0;
        end else begin
          cnt_next = cnt_q + 32'd1;
        end
      end
      SEND0: begin
        if (!bus.tx_busy) begin
          tx_start   = 1'b1;
          tx_data    = resp0_q;
          state_next = WAIT_TX0;
        end
      end
      WAIT_TX0: begin
        if (!bus.tx_busy) state_next = SEND1;
      end
      SEND1: begin
        if (!bus.tx_busy) begin
          tx_start   = 1'b1;
          tx_data    = resp1_q;
          state_next = WAIT_TX1;
        end
      end
      WAIT_TX1: begin
        if (!bus.tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sensor_start = sensor_start;
  assign bus.sensor_sel   = addr_q[4:0];
  assign bus.sensor_code  = code_q;
  assign bus.tx_start     = tx_start;
  assign bus.tx_data      = tx_data;
  assign bus.busy         = busy;
  assign bus.dropped      = dropped_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Randomised self-checking bench for uart_cmd_controller with a transaction-level
// response model and a simple UART transmitter model.
module tb_uart_cmd_controller;

  localparam int TIMEOUT     = 100;
  localparam int NUM_SENSORS = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  uart_cmd_controller_if bus();

  uart_cmd_controller #(
    .TimeoutCycles(TIMEOUT),
    .NumSensors   (NUM_SENSORS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed activity, with the cycle in which it was seen.
  int         sst_cyc[$];
  logic [4:0] sst_sel[$];
  logic [7:0] sst_code[$];
  int         tx_cyc[$];
  logic [7:0] tx_q[$];
  int         tx_len   = 2;
  bit         tx_block = 1'b0;
  int         tx_hold  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected response from the frame contents and the sensor outcome.
  function automatic logic [15:0] ref_resp(input logic [7:0] code, input logic [7:0] addr,
                                           input bit timeout, input bit err, input logic [7:0] value);
    logic [7:0] ok_tag [3];
    ok_tag = '{8'h07, 8'h09, 8'h08};
    if (code > 8'h02) return {8'h0E, code};
    if (int'(addr) >= NUM_SENSORS) return {8'h0F, addr};
    if (timeout) return 16'h1E00;
    if (err) return 16'h1F00;
    return {ok_tag[code], (code == 8'h00) ? 8'h00 : value};
  endfunction

  // Monitor and transmitter model: tx_busy rises the cycle after an accepted tx_start.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sensor_start === 1'b1) begin
        sst_cyc.push_back(cyc);
        sst_sel.push_back(bus.sensor_sel);
        sst_code.push_back(bus.sensor_code);
      end
      if (bus.tx_start === 1'b1) begin
        tx_cyc.push_back(cyc);
        tx_q.push_back(bus.tx_data);
        if (!bus.tx_busy) tx_hold = tx_len;
      end
      @(posedge clk);
      #2;
      bus.tx_busy = tx_block || (tx_hold > 0);
      if (tx_hold > 0) tx_hold--;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    sst_cyc.delete(); sst_sel.delete(); sst_code.delete();
    tx_cyc.delete(); tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_eop, output int at);
    bus.rx_ready       = 1'b1;
    bus.rx_data        = b;
    bus.rx_endofpacket = with_eop;
    at = cyc;
    tick(1);
    bus.rx_ready       = 1'b0;
    bus.rx_endofpacket = 1'b0;
    bus.rx_data        = 8'h00;
  endtask

  task automatic pulse_done(input bit err, input logic [7:0] value);
    bus.sensor_done  = 1'b1;
    bus.sensor_error = err;
    bus.sensor_value = value;
    tick(1);
    bus.sensor_done  = 1'b0;
    bus.sensor_error = 1'b0;
    bus.sensor_value = 8'h00;
  endtask

  task automatic run_frame(input logic [7:0] code, input logic [7:0] addr, input bit timeout,
                           input int delay, input logic [7:0] value, input bit err,
                           input bit stall, input bit eop_on_addr);
    int t, r, s, first_exp, c_idle, junk;
    bit valid;
    logic [15:0] exp;
    clear_obs();
    valid = (code <= 8'h02) && (int'(addr) < NUM_SENSORS);
    exp   = ref_resp(code, addr, timeout, err, value);
    send_byte(code, 1'b0, junk);
    send_byte(addr, eop_on_addr, t);
    first_exp = t + 2;
    if (valid) begin
      for (int i = 0; i < 10 && sst_cyc.size() == 0; i++) tick(1);
      check_eq("sensor_start_seen", sst_cyc.size(), 1);
      r = (sst_cyc.size() > 0) ? sst_cyc[0] : t + 2;
      if (sst_cyc.size() > 0) begin
        check_eq("sensor_start_cycle", r, t + 2);
        check_eq("sensor_sel", sst_sel[0], addr[4:0]);
        check_eq("sensor_code", sst_code[0], code);
      end
      if (stall) begin
        tx_block = 1'b1;
        send_byte(8'hAA, 1'b0, junk);
      end
      if (timeout) begin
        first_exp = r + TIMEOUT + 1;
      end else begin
        while (cyc < r + delay) tick(1);
        s = cyc;
        pulse_done(err, value);
        first_exp = s + 1;
        if (stall) begin
          while (cyc < s + 51) tick(1);
          check_eq("no_tx_while_busy", tx_q.size(), 0);
          tx_block  = 1'b0;
          first_exp = s + 51;
        end
      end
    end
    for (int i = 0; i < 400 && tx_q.size() < 2; i++) tick(1);
    check_eq("tx_count", tx_q.size(), 2);
    if (tx_q.size() >= 2) begin
      check_eq("tx_byte0", tx_q[0], exp[15:8]);
      check_eq("tx_byte1", tx_q[1], exp[7:0]);
      check_eq("tx0_cycle", tx_cyc[0], first_exp);
      check_eq("tx1_cycle", tx_cyc[1], tx_cyc[0] + tx_len + 2);
      c_idle = -1;
      for (int i = 0; i < 50 && c_idle < 0; i++) begin
        if (bus.busy === 1'b0) c_idle = cyc;
        else tick(1);
      end
      check_eq("busy_fall_cycle", c_idle, tx_cyc[1] + tx_len + 2);
    end
    check_eq("sensor_start_count", sst_cyc.size(), valid ? 1 : 0);
  endtask

  initial begin
    int junk;
    bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.rx_endofpacket = 1'b0;
    bus.sensor_done = 1'b0; bus.sensor_error = 1'b0; bus.sensor_value = 8'h00;

    // Reset state
    tick(3);
    check_eq("rst_sensor_start", bus.sensor_start, 0);
    check_eq("rst_sel_code", {bus.sensor_sel, bus.sensor_code}, 0);
    check_eq("rst_tx", {bus.tx_start, bus.tx_data}, 0);
    check_eq("rst_busy_dropped", {bus.busy, bus.dropped}, 0);
    reset = 1'b0;
    tick(2);

    // Directed cases
    run_frame(8'h01, 8'h03, 0, 10, 8'h19, 0, 0, 0);
    run_frame(8'h05, 8'h00, 0, 1, 8'h00, 0, 0, 0);
    run_frame(8'h02, 8'h25, 0, 1, 8'h00, 0, 0, 0);
    run_frame(8'h02, 8'h1F, 0, 3, 8'h77, 0, 0, 0);
    run_frame(8'h00, 8'h01, 1, 0, 8'h00, 0, 0, 0);
    clear_obs();
    pulse_done(1'b0, 8'h55);
    tick(10);
    check_eq("late_done_ignored", {tx_q.size(), bus.busy}, 0);
    run_frame(8'h01, 8'h02, 0, TIMEOUT, 8'h66, 0, 0, 0);

    // Line-idle gap abandons a half frame; simultaneous gap and byte keeps the byte
    send_byte(8'h01, 1'b0, junk);
    bus.rx_endofpacket = 1'b1;
    tick(1);
    bus.rx_endofpacket = 1'b0;
    tick(2);
    check_eq("eop_busy", bus.busy, 0);
    run_frame(8'h02, 8'h04, 0, 5, 8'h40, 0, 0, 0);
    run_frame(8'h01, 8'h07, 0, 4, 8'h21, 0, 0, 1);
    check_eq("dropped_before", bus.dropped, 0);

    // Transmitter stall and dropped byte
    run_frame(8'h01, 8'h05, 0, 10, 8'h33, 0, 1, 0);
    check_eq("dropped_set", bus.dropped, 1);
    run_frame(8'h00, 8'h09, 0, 2, 8'h00, 0, 0, 0);
    check_eq("dropped_sticky", bus.dropped, 1);

    // Reset while waiting on the sensor
    clear_obs();
    send_byte(8'h00, 1'b0, junk);
    send_byte(8'h05, 1'b0, junk);
    tick(6);
    check_eq("mid_busy", bus.busy, 1);
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_outputs", {bus.sensor_start, bus.sensor_sel, bus.sensor_code, bus.tx_start, bus.tx_data}, 0);
    check_eq("mid_rst_flags", {bus.busy, bus.dropped}, 0);
    reset = 1'b0;
    clear_obs();
    tick(1);
    pulse_done(1'b0, 8'h12);
    tick(30);
    check_eq("post_rst_quiet", {tx_q.size(), sst_cyc.size()}, 0);
    check_eq("post_rst_busy", bus.busy, 0);
    run_frame(8'h00, 8'h00, 0, 6, 8'hFF, 1, 0, 0);

    // Randomised frames
    for (int n = 0; n < 40; n++) begin
      logic [7:0] code, addr;
      code   = ($urandom_range(0, 4) == 4) ? 8'($urandom) : 8'($urandom_range(0, 3));
      addr   = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, NUM_SENSORS - 1)) : 8'($urandom);
      tx_len = $urandom_range(1, 4);
      tick($urandom_range(0, 3));
      run_frame(code, addr, $urandom_range(0, 7) == 0, $urandom_range(1, 20), 8'($urandom),
                $urandom_range(0, 3) == 0, 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_controller.md
# uart_cmd_controller

Command sequencer between the UART receive/transmit path and the sensor interface. Assembles 2-byte command frames from the UART receiver, validates them, issues one read request to the selected sensor, waits for its result with a timeout, then drives the UART transmitter with a 2-byte response. It is the only master of the sensor bus and the transmitter in the FPGA top level.

## Interface
- ClkFrequency, 50000000: system clock in Hz; informational, used to derive the TimeoutCycles default.
- TimeoutCycles, 50000000: sensor response timeout in clk cycles, 1 s at default. Legal range is 1 to 2^32-1.
- NumSensors, 32: number of valid sensor addresses, 1..32. An address is valid when it is less than NumSensors.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_ready  in  1  one-cycle strobe; rx_data is valid on this cycle.
- rx_data  in  8  received byte.
- rx_endofpacket  in  1  one-cycle strobe; marks a line-idle gap after a burst.
- sensor_start  out  1  one-cycle request pulse.
- sensor_sel  out  5  sensor address, held from sensor_start until the result is consumed.
- sensor_code  out  8  command code, held the same as sensor_sel.
- sensor_done  in  1  one-cycle result strobe.
- sensor_error  in  1  valid with sensor_done.
- sensor_value  in  8  valid with sensor_done.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  valid only while tx_start=1.
- tx_busy  in  1  transmitter busy; rises the cycle after an accepted tx_start.
- busy  out  1  high in every state except IDLE and WAIT_ADDR.
- dropped  out  1  sticky; set when a byte arrives while busy=1; cleared only by reset.

## Operation
- Frame format: byte0 is the command code, byte1 is the sensor address.
- Valid codes:
  - 0x00: sensor status.
  - 0x01: temperature.
  - 0x02: humidity.
- States: IDLE, WAIT_ADDR, CHECK, REQ, WAIT_SENSOR, SEND0, WAIT_TX0, SEND1, WAIT_TX1.
- IDLE: on rx_ready, latch byte0 and go to WAIT_ADDR.
- WAIT_ADDR:
  - rx_ready: latch byte1 and go to CHECK.
  - rx_endofpacket with no rx_ready: discard byte0 and return to IDLE.
  - Both on the same cycle: rx_ready wins.
- CHECK:
  - code > 0x02: resp0=0x0E, resp1=byte0, go to SEND0.
  - Otherwise, address >= NumSensors: resp0=0x0F, resp1=byte1, go to SEND0.
  - Code is checked before address.
  - Otherwise go to REQ.
- REQ: assert sensor_start for one cycle, clear the timeout counter, go to WAIT_SENSOR.
- WAIT_SENSOR:
  - sensor_done and sensor_error=1: resp0=0x1F, resp1=0x00.
  - sensor_done and sensor_error=0:
    - code 0x00: resp0=0x07, resp1=0x00.
    - code 0x01: resp0=0x09, resp1=sensor_value.
    - code 0x02: resp0=0x08, resp1=sensor_value.
  - Counter reaches TimeoutCycles-1 without sensor_done: resp0=0x1E, resp1=0x00.
  - sensor_done on the timeout cycle: sensor_done wins.
  - Every exit goes to SEND0.
- SEND0 / SEND1: when tx_busy=0, pulse tx_start with resp0 / resp1 and go to WAIT_TX0 / WAIT_TX1. Otherwise stall.
- WAIT_TX0 / WAIT_TX1: wait for tx_busy=0, then go to SEND1 / IDLE.
- A sensor_done outside WAIT_SENSOR is ignored.
- A rx_ready outside IDLE/WAIT_ADDR is discarded and sets dropped.

## Timing
- Reset values: all outputs 0, state IDLE, latched bytes 0, timeout counter 0. Reset has priority over every input on the same edge.
- Reset mid-operation: the frame is abandoned, no tx_start or sensor_start issues after the reset edge, and a later sensor_done is ignored.
- Valid command: byte1 rx_ready in cycle T gives CHECK in T+1 and sensor_start=1 in T+2.
- Invalid command: byte1 in T gives SEND0 in T+2; tx_start fires in T+2 if tx_busy=0.
- Sensor result: sensor_done in cycle S gives SEND0 in S+1; first tx_start in S+1 when tx_busy=0.
- Timeout: sensor_start in cycle R gives resp0=0x1E entering SEND0 at R+TimeoutCycles+1.
- Back-to-back: the next frame can start the cycle after WAIT_TX1 exits; busy falls in that same cycle.
- Counter is 32 bits and does not wrap within a request.

## Test plan
- Frame 0x01,0x03, then sensor_done after 10 cycles with value 0x19, error 0 -> sensor_start at T+2 with sel=3, code=0x01; TX bytes 0x09, 0x19.
- Frame 0x05,0x00 -> no sensor_start; TX bytes 0x0E, 0x05. Frame 0x02,0x25 with NumSensors=32 -> TX bytes 0x0F, 0x25.
- TimeoutCycles=100, frame 0x00,0x01, no sensor_done -> TX bytes 0x1E, 0x00 with the first tx_start exactly 101 cycles after sensor_start. A sensor_done pulsed later is ignored.
- Byte 0x01 then rx_endofpacket -> return to IDLE. A following frame 0x02,0x04 with value 0x40 -> TX bytes 0x08, 0x40.
- Hold tx_busy=1 for 50 cycles in SEND0; rx_ready during WAIT_SENSOR -> tx_start waits for tx_busy=0; dropped=1 and stays 1.
- Assert reset in WAIT_SENSOR, then pulse sensor_done -> all outputs 0 and no tx_start. A new frame 0x00,0x00 with error=1 -> TX bytes 0x1F, 0x00.
